// File: rtl/apb_regbank_pkg.sv
// rtl/apb_regbank_pkg.sv - shared types and width helpers for the APB register bank
package apb_regbank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_ALIGN = 3'd1,
        ERR_RANGE = 3'd2,
        ERR_RO    = 3'd3,
        ERR_PRIV  = 3'd4
    } err_t;

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // An empty read-only region keeps a 1-bit unused port.
    function automatic int ro_w(input int n, input int ro_base, input int dw);
        return (n > ro_base) ? (n - ro_base) * dw : 1;
    endfunction

endpackage

// File: rtl/apb_regbank_core.sv
// rtl/apb_regbank_core.sv - register storage with byte-strobed write port and read mux
module apb_regbank_core
    import apb_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int RO_BASE    = NUM_REGS
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_wr_en,
    input  logic [idx_w(NUM_REGS)-1:0]                    i_wr_idx,
    input  logic [DATA_WIDTH-1:0]                         i_wr_data,
    input  logic [strb_w(DATA_WIDTH)-1:0]                 i_wr_strb,
    input  logic [idx_w(NUM_REGS)-1:0]                    i_rd_idx,
    input  logic [ro_w(NUM_REGS, RO_BASE, DATA_WIDTH)-1:0] i_ro_data,
    output logic [DATA_WIDTH-1:0]                         o_rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0]                o_reg_q
);

    localparam int IDX_W  = idx_w(NUM_REGS);
    localparam int STRB_W = strb_w(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic                  w_unused_ro;

    assign w_unused_ro = ^i_ro_data;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i < RO_BASE) begin : g_rw
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_q <= '0;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (i_wr_strb[b]) begin
                            r_q[b*8 +: 8] <= i_wr_data[b*8 +: 8];
                        end
                    end
                end
            end

            assign w_regs[i] = r_q;
        end else begin : g_ro
            // Read-only entries mirror the hardware-supplied value.
            assign w_regs[i] = i_ro_data[(i-RO_BASE)*DATA_WIDTH +: DATA_WIDTH];
        end

        assign o_reg_q[i*DATA_WIDTH +: DATA_WIDTH] = w_regs[i];
    end

    assign o_rd_data = w_regs[i_rd_idx];

endmodule

// File: rtl/apb_regbank_slave.sv
// rtl/apb_regbank_slave.sv - APB4 completer with wait states, decode errors and register bank
module apb_regbank_slave
    import apb_regbank_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0,
    parameter int RO_BASE     = NUM_REGS,
    parameter int PRIV_WR     = 0
) (
    input  logic                                          PCLK,
    input  logic                                          PRESET,
    input  logic                                          PSEL,
    input  logic                                          PENABLE,
    input  logic                                          PWRITE,
    input  logic [ADDR_WIDTH-1:0]                         PADDR,
    input  logic [DATA_WIDTH-1:0]                         PWDATA,
    input  logic [DATA_WIDTH/8-1:0]                       PSTRB,
    input  logic [2:0]                                    PPROT,
    input  logic [ro_w(NUM_REGS, RO_BASE, DATA_WIDTH)-1:0] ro_data,
    output logic                                          PREADY,
    output logic [DATA_WIDTH-1:0]                         PRDATA,
    output logic                                          PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0]                reg_q
);

    localparam int STRB_W = strb_w(DATA_WIDTH);
    localparam int IDX_W  = idx_w(NUM_REGS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_write;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]   r_strb;
    err_t                r_err;

    err_t                w_err;
    logic [IDX_W-1:0]    w_idx;
    logic                w_latch;
    logic                w_ready;
    logic                w_commit;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                w_unused;

    assign w_unused = ^PPROT[2:1];
    assign w_idx    = PADDR[IDX_W+1:2];

    // Error cause is resolved from the live setup-phase signals.
    always_comb begin
        w_err = ERR_NONE;
        if (PADDR[1:0] != 2'b00) begin
            w_err = ERR_ALIGN;
        end else if (PADDR[ADDR_WIDTH-1:IDX_W+2] != '0) begin
            w_err = ERR_RANGE;
        end else if (PWRITE && (int'(w_idx) >= RO_BASE)) begin
            w_err = ERR_RO;
        end else if (PWRITE && (PRIV_WR != 0) && !PPROT[0]) begin
            w_err = ERR_PRIV;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = 4'(WAIT_STATES);
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_ready     = !PRESET;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_write <= PWRITE;
                r_idx   <= w_idx;
                r_wdata <= PWDATA;
                r_strb  <= PSTRB;
                r_err   <= w_err;
            end
        end
    end

    assign w_commit = w_ready && r_write && (r_err == ERR_NONE);

    apb_regbank_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_BASE    (RO_BASE)
    ) u_core (
        .i_clk      (PCLK),
        .i_rst      (PRESET),
        .i_wr_en    (w_commit),
        .i_wr_idx   (r_idx),
        .i_wr_data  (r_wdata),
        .i_wr_strb  (r_strb),
        .i_rd_idx   (r_idx),
        .i_ro_data  (ro_data),
        .o_rd_data  (w_rdata),
        .o_reg_q    (reg_q)
    );

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && (r_err != ERR_NONE);
    assign PRDATA  = (w_ready && !r_write && (r_err == ERR_NONE)) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb/tb_apb_regbank_slave.sv - directed self-checking bench for apb_regbank_slave
module tb_apb_regbank_slave;

    logic         clk = 1'b0;
    logic         preset;
    logic         psel_a, psel_b, penable, pwrite;
    logic [31:0]  paddr, pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic         pready_a, pslverr_a, pready_b, pslverr_b;
    logic [31:0]  prdata_a, prdata_b;
    logic [511:0] reg_q_a, reg_q_b;
    logic [63:0]  ro_a = {32'hCAFEF00D, 32'h0BADC0DE};
    logic         ro_b = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] rd;
    logic        er;
    int          wt;

    always #5 clk = ~clk;

    // A: no wait states, registers 14..15 read-only
    apb_regbank_slave #(
        .WAIT_STATES (0),
        .RO_BASE     (14),
        .PRIV_WR     (0)
    ) dut_a (
        .PCLK    (clk),
        .PRESET  (preset),
        .PSEL    (psel_a),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PSTRB   (pstrb),
        .PPROT   (pprot),
        .ro_data (ro_a),
        .PREADY  (pready_a),
        .PRDATA  (prdata_a),
        .PSLVERR (pslverr_a),
        .reg_q   (reg_q_a)
    );

    // B: three wait states, privileged writes only, all registers writable
    apb_regbank_slave #(
        .WAIT_STATES (3),
        .PRIV_WR     (1)
    ) dut_b (
        .PCLK    (clk),
        .PRESET  (preset),
        .PSEL    (psel_b),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PSTRB   (pstrb),
        .PPROT   (pprot),
        .ro_data (ro_b),
        .PREADY  (pready_b),
        .PRDATA  (prdata_b),
        .PSLVERR (pslverr_b),
        .reg_q   (reg_q_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rdata, output logic err, output int waits);
        logic got;
        got   = 1'b0;
        rdata = 'x;
        err   = 1'bx;
        waits = 0;
        @(posedge clk); #1;
        psel_a  = (which == 0);
        psel_b  = (which == 1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        pprot   = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ((which == 0) ? pready_a : pready_b) begin
                got   = 1'b1;
                rdata = (which == 0) ? prdata_a : prdata_b;
                err   = (which == 0) ? pslverr_a : pslverr_b;
                break;
            end
            waits++;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $error("FAIL xfer_timeout: observed no PREADY, expected PREADY within 40 cycles");
        end
        @(posedge clk); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge clk);
        #1 preset = 1'b0;
        @(negedge clk);
        check("rst_pready", {31'b0, pready_a}, 32'd0);
        check("rst_pslverr", {31'b0, pslverr_a}, 32'd0);
        check("rst_prdata", prdata_a, 32'd0);
        check("rst_regq_rw_zero", {31'b0, |reg_q_a[447:0]}, 32'd0);
        check("rst_regq_ro15", reg_q_a[15*32 +: 32], 32'hCAFEF00D);

        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, wt);
        check("wr08_err", {31'b0, er}, 32'd0);
        check("wr08_waits", wt, 32'd0);
        check("wr08_regq2", reg_q_a[2*32 +: 32], 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("rd08_data", rd, 32'hDEADBEEF);
        check("rd08_err", {31'b0, er}, 32'd0);
        check("rd08_waits", wt, 32'd0);

        xfer(0, 1'b1, 32'h04, 32'h11223344, 4'hF, 3'b000, rd, er, wt);
        xfer(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, 3'b000, rd, er, wt);
        check("strb_err", {31'b0, er}, 32'd0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("strb_readback", rd, 32'h11BB33DD);
        xfer(0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 3'b000, rd, er, wt);
        check("strb0_err", {31'b0, er}, 32'd0);
        check("strb0_noop", reg_q_a[1*32 +: 32], 32'h11BB33DD);

        xfer(0, 1'b1, 32'h06, 32'h01010101, 4'hF, 3'b000, rd, er, wt);
        check("misalign_err", {31'b0, er}, 32'd1);
        check("misalign_prdata", rd, 32'd0);
        check("misalign_reg1", reg_q_a[1*32 +: 32], 32'h11BB33DD);
        xfer(0, 1'b1, 32'h40, 32'h02020202, 4'hF, 3'b000, rd, er, wt);
        check("range_err", {31'b0, er}, 32'd1);
        check("range_prdata", rd, 32'd0);
        check("range_reg0", reg_q_a[0 +: 32], 32'd0);
        xfer(0, 1'b1, 32'h38, 32'h03030303, 4'hF, 3'b000, rd, er, wt);
        check("ro_wr_err", {31'b0, er}, 32'd1);
        check("ro_wr_reg14", reg_q_a[14*32 +: 32], 32'h0BADC0DE);
        xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("ro_rd15_data", rd, 32'hCAFEF00D);
        check("ro_rd15_err", {31'b0, er}, 32'd0);
        xfer(0, 1'b0, 32'h38, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("ro_rd14_data", rd, 32'h0BADC0DE);
        xfer(0, 1'b0, 32'h05, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("misalign_rd_err", {31'b0, er}, 32'd1);
        check("misalign_rd_prdata", rd, 32'd0);

        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("ws3_waits", wt, 32'd3);
        check("ws3_err", {31'b0, er}, 32'd0);
        check("ws3_data", rd, 32'd0);
        xfer(1, 1'b1, 32'h00, 32'h77777777, 4'hF, 3'b000, rd, er, wt);
        check("priv_err", {31'b0, er}, 32'd1);
        check("priv_prdata", rd, 32'd0);
        check("priv_reg0", reg_q_b[0 +: 32], 32'd0);
        xfer(1, 1'b1, 32'h00, 32'h12345678, 4'hF, 3'b001, rd, er, wt);
        check("priv_ok_err", {31'b0, er}, 32'd0);
        check("priv_ok_reg0", reg_q_b[0 +: 32], 32'h12345678);

        // Abort: drop PSEL part-way through the access phase of a write.
        @(posedge clk); #1;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04;
        pwdata = 32'h00000055; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        check("abort_ready_low", {31'b0, pready_b}, 32'd0);
        @(posedge clk); #1;
        psel_b = 1'b0; penable = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("abort_no_commit", reg_q_b[1*32 +: 32], 32'd0);
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("post_abort_data", rd, 32'h12345678);
        check("post_abort_waits", wt, 32'd3);

        // Reset lands in the cycle that would otherwise be the PREADY/commit cycle.
        @(posedge clk); #1;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
        pwdata = 32'h99999999; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        repeat (3) @(posedge clk);
        #1 preset = 1'b1;
        @(negedge clk);
        check("rstmid_pready", {31'b0, pready_b}, 32'd0);
        check("rstmid_pslverr", {31'b0, pslverr_b}, 32'd0);
        check("rstmid_prdata", prdata_b, 32'd0);
        @(posedge clk); #1;
        psel_b = 1'b0; penable = 1'b0;
        @(posedge clk); #1 preset = 1'b0;
        check("rstmid_regq_zero", {31'b0, |reg_q_b}, 32'd0);
        xfer(1, 1'b1, 32'h08, 32'hA5A5A5A5, 4'hF, 3'b001, rd, er, wt);
        check("post_rst_wr_err", {31'b0, er}, 32'd0);
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("post_rst_rd_data", rd, 32'hA5A5A5A5);
        check("post_rst_rd_waits", wt, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
